// File: rtl/sar_scan_sequencer.sv
// sar_scan_sequencer
// Steps an analog mux through the enabled channels. For each channel it waits
// a settling time, then runs one conversion on the 3-bit SAR and stores the
// result in that channel's slot of the results register.
//
// Ports
//   clock, reset     rising-edge clock, asynchronous active-low reset
//   start            one-cycle scan request, honoured only while idle
//   mode             0 = single scan, 1 = continuous scan
//   stop             one-cycle request to end scanning after the current conversion
//   chEnable[NCH]    channel enable mask, latched when a scan starts
//   nEndCnv          SAR end-of-conversion, high while converting
//   sarData[3]       SAR result, valid when nEndCnv falls
//   nStartCnv        active-low conversion request to the SAR
//   chSel            analog mux select
//   results[3*NCH]   channel i result in bits [3i+2:3i]
//   valid[NCH]       result for channel i is fresh in this scan
//   scanDone         one-cycle pulse at the end of a completed scan
//   busy             high whenever the sequencer is not idle
//   timeoutErr       sticky conversion timeout flag, cleared when a start is accepted
//   fsm_state        current FSM state, for observation
//
// SAR handshake: the sequencer drives nStartCnv low and holds it low until the
// SAR acknowledges by raising nEndCnv; it then releases nStartCnv at once (a
// request still low when the SAR finishes would restart it) and waits for
// nEndCnv to fall, sampling sarData on that cycle. Both phases together are
// bounded by TIMEOUT cycles.
module sar_scan_sequencer #(
  parameter int NCH     = 4,
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 31
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     mode,
  input  logic                     stop,
  input  logic [NCH-1:0]           chEnable,
  input  logic                     nEndCnv,
  input  logic [2:0]               sarData,
  output logic                     nStartCnv,
  output logic [$clog2(NCH)-1:0]   chSel,
  output logic [3*NCH-1:0]         results,
  output logic [NCH-1:0]           valid,
  output logic                     scanDone,
  output logic                     busy,
  output logic                     timeoutErr,
  output logic [2:0]               fsm_state
);

  localparam int CW = $clog2(NCH);
  localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_SETTLE, S_START, S_WAITACK, S_WAITEND, S_STORE, S_NEXT
  } state_t;

  state_t          state, state_d;
  logic [NCH-1:0]  en_mask, mask_d;
  logic [CW-1:0]   ptr, ptr_d;
  logic [SW-1:0]   scnt, scnt_d;
  logic [TW-1:0]   tcnt, tcnt_d;
  logic [2:0]      data_q, data_d;
  logic            stop_req, stop_d;
  logic            nstart_d, done_d, busy_d, terr_d;
  logic [CW-1:0]   chsel_d;
  logic [3*NCH-1:0] results_d;
  logic [NCH-1:0]  valid_d;
  logic [CW-1:0]   sel_lo;
  logic            higher;
  logic            tmo_hit;

  assign fsm_state = state;
  assign tmo_hit   = (tcnt == TW'(TIMEOUT - 1));

  // Lowest enabled channel at or above the scan pointer.
  always_comb begin
    sel_lo = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (en_mask[i] && (i >= int'(ptr))) sel_lo = CW'(i);
    end
  end

  // Is any enabled channel above the one just converted?
  always_comb begin
    higher = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (en_mask[i] && (i > int'(chSel))) higher = 1'b1;
    end
  end

  always_comb begin
    state_d   = state;
    mask_d    = en_mask;
    ptr_d     = ptr;
    scnt_d    = scnt;
    tcnt_d    = tcnt;
    data_d    = data_q;
    stop_d    = stop_req;
    nstart_d  = nStartCnv;
    chsel_d   = chSel;
    results_d = results;
    valid_d   = valid;
    done_d    = 1'b0;
    terr_d    = timeoutErr;

    if ((state != S_IDLE) && stop) stop_d = 1'b1;

    case (state)
      S_IDLE: begin
        if (start) begin
          mask_d  = chEnable;
          valid_d = '0;
          terr_d  = 1'b0;
          ptr_d   = '0;
          if (chEnable == '0) done_d = 1'b1;
          else                state_d = S_SELECT;
        end
      end
      S_SELECT: begin
        chsel_d = sel_lo;
        scnt_d  = SW'(SETTLE);
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (scnt == '0) state_d = S_START;
        else            scnt_d  = scnt - 1'b1;
      end
      S_START: begin
        nstart_d = 1'b0;
        tcnt_d   = '0;
        state_d  = S_WAITACK;
      end
      S_WAITACK: begin
        tcnt_d = tcnt + 1'b1;
        if (nEndCnv) begin
          nstart_d = 1'b1;
          state_d  = S_WAITEND;
        end else if (tmo_hit) begin
          nstart_d = 1'b1;
          terr_d   = 1'b1;
          state_d  = S_NEXT;
        end
      end
      S_WAITEND: begin
        tcnt_d = tcnt + 1'b1;
        // A conversion that ends on the timeout cycle still counts as good.
        if (!nEndCnv) begin
          data_d  = sarData;
          state_d = S_STORE;
        end else if (tmo_hit) begin
          terr_d  = 1'b1;
          state_d = S_NEXT;
        end
      end
      S_STORE: begin
        results_d[3*int'(chSel) +: 3] = data_q;
        valid_d[chSel]                = 1'b1;
        state_d                       = S_NEXT;
      end
      S_NEXT: begin
        if (stop_req) begin
          state_d = S_IDLE;
        end else if (higher) begin
          ptr_d   = chSel + 1'b1;
          state_d = S_SELECT;
        end else begin
          done_d = 1'b1;
          if (mode) begin
            mask_d  = chEnable;
            valid_d = '0;
            ptr_d   = '0;
            state_d = (chEnable == '0) ? S_IDLE : S_SELECT;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A stop request never outlives the scan it ended or that ended anyway.
    if (state_d == S_IDLE) stop_d = 1'b0;
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      en_mask    <= '0;
      ptr        <= '0;
      scnt       <= '0;
      tcnt       <= '0;
      data_q     <= '0;
      stop_req   <= 1'b0;
      nStartCnv  <= 1'b1;
      chSel      <= '0;
      results    <= '0;
      valid      <= '0;
      scanDone   <= 1'b0;
      busy       <= 1'b0;
      timeoutErr <= 1'b0;
    end else begin
      state      <= state_d;
      en_mask    <= mask_d;
      ptr        <= ptr_d;
      scnt       <= scnt_d;
      tcnt       <= tcnt_d;
      data_q     <= data_d;
      stop_req   <= stop_d;
      nStartCnv  <= nstart_d;
      chSel      <= chsel_d;
      results    <= results_d;
      valid      <= valid_d;
      scanDone   <= done_d;
      busy       <= busy_d;
      timeoutErr <= terr_d;
    end
  end

endmodule

// File: tb/tb_sar_scan_sequencer.sv
// Bench for sar_scan_sequencer: directed scans against a SAR responder, with a
// per-cycle expected-output timeline built from conversion-cost arithmetic.
module tb_sar_scan_sequencer;

  localparam int NCH = 4, SETTLE = 2, TIMEOUT = 31;
  localparam int CW = 2, RW = 3 * NCH, CL = 3;
  localparam int VW = 1 + CW + RW + NCH + 3;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic             start, mode, stop;
  logic [NCH-1:0]   chEnable;
  logic             nEndCnv = 1'b0;
  logic [2:0]       sarData = 3'd0;
  logic             nStartCnv;
  logic [CW-1:0]    chSel;
  logic [RW-1:0]    results;
  logic [NCH-1:0]   valid;
  logic             scanDone, busy, timeoutErr;
  logic [2:0]       fsm_state;

  sar_scan_sequencer #(.NCH(NCH), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .start(start), .mode(mode), .stop(stop),
    .chEnable(chEnable), .nEndCnv(nEndCnv), .sarData(sarData),
    .nStartCnv(nStartCnv), .chSel(chSel), .results(results), .valid(valid),
    .scanDone(scanDone), .busy(busy), .timeoutErr(timeoutErr), .fsm_state(fsm_state)
  );

  int tests = 0, fails = 0;

  // ---------------- SAR responder ----------------
  // Acknowledges on the first negedge it sees nStartCnv low, converts for CL
  // cycles, then drops nEndCnv with the value for that conversion number.
  logic [2:0] vals [16];
  int  hang_conv = -1;
  int  sar_n = 0, sar_cnt = 0, cur_idx = 0;
  bit  sar_busy = 0;
  logic prev_ns = 1'b1;

  always @(negedge clock) begin
    if (!reset) begin
      sar_busy = 0;
      nEndCnv  = 1'b0;
      prev_ns  = 1'b1;
    end else begin
      if (sar_busy) begin
        sar_cnt--;
        if (sar_cnt == 0) begin
          nEndCnv  = 1'b0;
          sarData  = vals[cur_idx];
          sar_busy = 0;
        end
      end else if (prev_ns && !nStartCnv) begin
        if (sar_n != hang_conv) begin
          nEndCnv  = 1'b1;
          sar_cnt  = CL;
          sar_busy = 1;
          cur_idx  = sar_n;
        end
        sar_n++;
      end
      prev_ns = nStartCnv;
    end
  end

  // ---------------- model ----------------
  logic [2:0]     m_res [NCH];
  logic [NCH-1:0] m_valid;
  logic           m_terr;
  logic [CW-1:0]  m_chsel;
  logic [VW-1:0]  exp_q [$];

  function automatic void push(input logic ns, input logic dn, input logic bz);
    logic [RW-1:0] r;
    for (int c = 0; c < NCH; c++) r[3*c +: 3] = m_res[c];
    exp_q.push_back({ns, m_chsel, r, m_valid, dn, bz, m_terr});
  endfunction

  // One entry per cycle from the accepting edge onward. Each conversion costs
  // select(1) + settle(SETTLE+1) + start(1) + ack(1) + convert(CL) + store(1) + next(1).
  task automatic gen_scan(input logic [NCH-1:0] mask, input logic md,
                          input int stop_conv, input int hang);
    int n = 0;
    bit fin = 0, e_pushed = 0, last;
    m_valid = '0;
    m_terr  = 1'b0;
    if (mask == '0) begin
      push(1'b1, 1'b1, 1'b0);
      fin = 1;
    end
    while (!fin && n < 40) begin
      for (int c = 0; c < NCH; c++) begin
        if (mask[c] && !fin) begin
          if (!e_pushed) push(1'b1, 1'b0, 1'b1);
          e_pushed = 0;
          m_chsel = CW'(c);
          repeat (SETTLE + 2) push(1'b1, 1'b0, 1'b1);
          if (n == hang) begin
            repeat (TIMEOUT) push(1'b0, 1'b0, 1'b1);
            m_terr = 1'b1;
            push(1'b1, 1'b0, 1'b1);
          end else begin
            push(1'b0, 1'b0, 1'b1);
            repeat (CL + 1) push(1'b1, 1'b0, 1'b1);
            m_res[c]   = vals[n];
            m_valid[c] = 1'b1;
            push(1'b1, 1'b0, 1'b1);
          end
          last = 1;
          for (int j = c + 1; j < NCH; j++) if (mask[j]) last = 0;
          if (n == stop_conv) begin
            push(1'b1, 1'b0, 1'b0);
            fin = 1;
          end else if (last) begin
            if (md) begin
              m_valid = '0;
              push(1'b1, 1'b1, 1'b1);
              e_pushed = 1;
            end else begin
              push(1'b1, 1'b1, 1'b0);
              fin = 1;
            end
          end
          n++;
        end
      end
    end
    repeat (3) push(1'b1, 1'b0, 1'b0);
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) m_res[c] = 3'd0;
    m_valid = '0;
    m_terr  = 1'b0;
    m_chsel = '0;
  endtask

  // ---------------- scoreboard / compare ----------------
  logic [VW-1:0] cmp_e, cmp_g;
  int cmp_k = 0, low_cnt = 0, low_run = 0, max_low = 0, done_cnt = 0;

  always @(posedge clock) begin
    #1;
    if (!nStartCnv) begin low_cnt++; low_run++; end
    else low_run = 0;
    if (low_run > max_low) max_low = low_run;
    if (scanDone) done_cnt++;
    if (exp_q.size() > 0) begin
      cmp_e = exp_q.pop_front();
      cmp_g = {nStartCnv, chSel, results, valid, scanDone, busy, timeoutErr};
      tests++;
      if (cmp_g !== cmp_e) begin
        fails++;
        $display("FAIL cycle_vec k=%0d got=%h exp=%h", cmp_k, cmp_g, cmp_e);
      end
      cmp_k++;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_nstart"}, 32'(nStartCnv), 32'd1);
    check({tag, "_chsel"}, 32'(chSel), 32'd0);
    check({tag, "_results"}, 32'(results), 32'd0);
    check({tag, "_valid"}, 32'(valid), 32'd0);
    check({tag, "_done"}, 32'(scanDone), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_terr"}, 32'(timeoutErr), 32'd0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic run_scan(input logic [NCH-1:0] mask, input logic md, input int stop_conv,
                          input int stop_at, input int hang, input bit stop_with_start);
    @(negedge clock);
    sar_n = 0; hang_conv = hang;
    low_cnt = 0; low_run = 0; max_low = 0; done_cnt = 0; cmp_k = 0;
    gen_scan(mask, md, stop_conv, hang);
    chEnable = mask; mode = md; start = 1'b1; stop = stop_with_start;
    @(negedge clock);
    start = 1'b0; stop = 1'b0;
    if (stop_at >= 0) begin
      repeat (stop_at) @(negedge clock);
      stop = 1'b1;
      @(negedge clock);
      stop = 1'b0;
    end
    for (int i = 0; i < 2000 && exp_q.size() > 0; i++) @(negedge clock);
    if (exp_q.size() > 0) begin
      tests++; fails++;
      $display("FAIL scan_timeout got=%0d exp=0 entries left", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic abort_at(input int at_k, input logic exp_ns, input string tag);
    @(negedge clock);
    sar_n = 0; hang_conv = -1;
    chEnable = 4'b0110; mode = 1'b0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (at_k) @(negedge clock);
    check({tag, "_pre_nstart"}, 32'(nStartCnv), 32'(exp_ns));
    check({tag, "_pre_busy"}, 32'(busy), 32'd1);
    #2 reset = 1'b0;
    #1 check_reset_outputs(tag);
    @(negedge clock);
    @(negedge clock);
    #1 reset = 1'b1;
    model_reset();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0; start = 1'b0; mode = 1'b0; stop = 1'b0; chEnable = '0;
    for (int i = 0; i < 16; i++) vals[i] = 3'd0;
    model_reset();

    // Reset with random inputs.
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      start = 1'($urandom_range(0, 1));
      mode  = 1'($urandom_range(0, 1));
      stop  = 1'($urandom_range(0, 1));
      chEnable = NCH'($urandom_range(0, 15));
      #2 check_reset_outputs("reset");
    end
    @(negedge clock);
    start = 1'b0; mode = 1'b0; stop = 1'b0; chEnable = '0;
    #1 reset = 1'b1;

    // Single scan over channels 0, 1, 3.
    vals[0] = 3'd5; vals[1] = 3'd2; vals[2] = 3'd7;
    run_scan(4'b1011, 1'b0, -1, -1, -1, 1'b0);
    check("single_results", 32'(results), 32'hE15);
    check("single_valid", 32'(valid), 32'b1011);
    check("single_done_cnt", 32'(done_cnt), 32'd1);
    check("single_low_run", 32'(max_low), 32'd1);
    check("single_busy", 32'(busy), 32'd0);

    // Empty mask.
    run_scan(4'b0000, 1'b0, -1, -1, -1, 1'b0);
    check("empty_done_cnt", 32'(done_cnt), 32'd1);
    check("empty_low_cnt", 32'(low_cnt), 32'd0);

    // Timeout on channel 1.
    vals[0] = 3'd6;
    run_scan(4'b0011, 1'b0, -1, -1, 1, 1'b0);
    check("tmo_low_run", 32'(max_low), 32'd31);
    check("tmo_terr", 32'(timeoutErr), 32'd1);
    check("tmo_valid", 32'(valid), 32'b0001);
    check("tmo_done_cnt", 32'(done_cnt), 32'd1);
    check("tmo_results", 32'(results), 32'hE16);

    // Continuous scan, stop during second scan's channel 1 conversion.
    vals[0] = 3'd1; vals[1] = 3'd4; vals[2] = 3'd6; vals[3] = 3'd3; vals[4] = 3'd5;
    run_scan(4'b0111, 1'b1, 4, 50, -1, 1'b0);
    check("cont_results", 32'(results), 32'hFAB);
    check("cont_valid", 32'(valid), 32'b0011);
    check("cont_done_cnt", 32'(done_cnt), 32'd1);
    check("cont_busy", 32'(busy), 32'd0);

    // Asynchronous reset with nStartCnv low, then high.
    abort_at(5, 1'b0, "arst_ack");
    abort_at(6, 1'b1, "arst_end");

    // Normal scan after reset; stop arriving with start is ignored.
    vals[0] = 3'd3; vals[1] = 3'd4;
    run_scan(4'b0101, 1'b0, -1, -1, -1, 1'b1);
    check("post_results", 32'(results), 32'h103);
    check("post_valid", 32'(valid), 32'b0101);
    check("post_done_cnt", 32'(done_cnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
